// File: rtl/ahb_pkg.sv
// Shared AHB type definitions: transfer types, burst encodings, arbiter states
// and the burst-length decode used by the multi-master arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_t;

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } arb_state_t;

  // Beats in a burst; 0 marks an unbounded INCR.
  function automatic logic [7:0] burst_beats(input burst_t burst);
    case (burst)
      SINGLE:         burst_beats = 8'd1;
      WRAP4, INCR4:   burst_beats = 8'd4;
      WRAP8, INCR8:   burst_beats = 8'd8;
      WRAP16, INCR16: burst_beats = 8'd16;
      default:        burst_beats = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, searching cyclically; returns one-hot grant, index and a valid flag.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_valid
);

  logic [IDX_W-1:0] w_cand;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NUM_MASTERS);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB slave port among NUM_MASTERS masters: round-robin grant held
// for a whole burst, with separate address-phase and data-phase owners.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS       = 2,
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int AHB_DATA_WIDTH    = 64
) (
  input  logic                                    HCLK,
  input  logic                                    HRESETn,
  input  logic [NUM_MASTERS*AHB_ADDRESS_WIDTH-1:0] m_HADDR,
  input  logic [NUM_MASTERS-1:0]                  m_HWRITE,
  input  logic [NUM_MASTERS*3-1:0]                m_HSIZE,
  input  logic [NUM_MASTERS*3-1:0]                m_HBURST,
  input  logic [NUM_MASTERS*2-1:0]                m_HTRANS,
  input  logic [NUM_MASTERS*AHB_DATA_WIDTH-1:0]   m_HWDATA,
  output logic [NUM_MASTERS-1:0]                  m_HREADY,
  output logic [NUM_MASTERS-1:0]                  m_HRESP,
  output logic [AHB_DATA_WIDTH-1:0]               m_HRDATA,
  output logic [AHB_ADDRESS_WIDTH-1:0]            HADDR,
  output logic                                    HWRITE,
  output logic [2:0]                              HSIZE,
  output logic [2:0]                              HBURST,
  output logic [1:0]                              HTRANS,
  output logic [AHB_DATA_WIDTH-1:0]               HWDATA,
  input  logic                                    HREADY,
  input  logic                                    HRESP,
  input  logic [AHB_DATA_WIDTH-1:0]               HRDATA,
  output logic [NUM_MASTERS-1:0]                  grant_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // Per-master views of the flattened input buses
  logic [AHB_ADDRESS_WIDTH-1:0] w_haddr  [NUM_MASTERS];
  logic [2:0]                   w_hsize  [NUM_MASTERS];
  burst_t                       w_hburst [NUM_MASTERS];
  state_t                       w_htrans [NUM_MASTERS];
  logic [AHB_DATA_WIDTH-1:0]    w_hwdata [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]       w_req;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign w_haddr[g]  = m_HADDR[g*AHB_ADDRESS_WIDTH +: AHB_ADDRESS_WIDTH];
    assign w_hsize[g]  = m_HSIZE[g*3 +: 3];
    assign w_hburst[g] = burst_t'(m_HBURST[g*3 +: 3]);
    assign w_htrans[g] = state_t'(m_HTRANS[g*2 +: 2]);
    assign w_hwdata[g] = m_HWDATA[g*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
    assign w_req[g]    = (w_htrans[g] == NONSEQ);
  end

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [7:0]             r_beat_cnt;
  logic                   r_first;
  logic [NUM_MASTERS-1:0] r_grant;
  logic                   r_d_valid;
  logic [IDX_W-1:0]       r_d_own;

  logic [NUM_MASTERS-1:0] w_win_gnt;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_any_req;
  logic [IDX_W-1:0]       w_next_ptr;

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr_arbiter (
    .i_req  (w_req),
    .i_ptr  (r_rr_ptr),
    .o_gnt  (w_win_gnt),
    .o_idx  (w_win_idx),
    .o_valid(w_any_req)
  );

  assign w_next_ptr = (w_win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_win_idx + IDX_W'(1);

  state_t     w_own_trans;
  logic [7:0] w_own_beats;
  logic       w_start;
  logic       w_release;
  logic [7:0] w_cnt_next;

  assign w_own_trans = w_htrans[r_owner];
  assign w_own_beats = burst_beats(w_hburst[r_owner]);

  // r_beat_cnt holds the beats still owed including the one on the bus;
  // 0 means an unbounded INCR that only an IDLE can end.
  always_comb begin
    w_start    = (w_own_trans == NONSEQ) || ((w_own_trans == SEQ) && r_first);
    w_release  = 1'b0;
    w_cnt_next = r_beat_cnt;
    if (w_own_trans == IDLE) begin
      w_release = 1'b1;
    end else if (w_start) begin
      if (w_own_beats == 8'd1)
        w_release = 1'b1;
      else if (w_own_beats != 8'd0)
        w_cnt_next = w_own_beats - 8'd1;
      else
        w_cnt_next = 8'd0;
    end else if (w_own_trans == SEQ) begin
      if (r_beat_cnt == 8'd1)
        w_release = 1'b1;
      else if (r_beat_cnt != 8'd0)
        w_cnt_next = r_beat_cnt - 8'd1;
    end
  end

  always_comb begin
    HTRANS = IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = 3'd0;
    HBURST = 3'd0;
    if (r_state == OWN) begin
      HTRANS = w_own_trans;
      HADDR  = w_haddr[r_owner];
      HWRITE = m_HWRITE[r_owner];
      HSIZE  = w_hsize[r_owner];
      HBURST = w_hburst[r_owner];
    end
  end

  // Nothing advances during a slave wait state: owner, count, data owner and
  // pointer all hold until HREADY returns.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ARB;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_first    <= 1'b0;
      r_grant    <= '0;
      r_d_valid  <= 1'b0;
      r_d_own    <= '0;
    end else if (HREADY) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_d_valid <= (HTRANS == NONSEQ) || (HTRANS == SEQ);
      r_d_own   <= r_owner;
      case (r_state)
        ARB: begin
          if (w_any_req) begin
            r_state    <= OWN;
            r_owner    <= w_win_idx;
            r_grant    <= w_win_gnt;
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
            r_first    <= 1'b1;
          end
        end
        OWN: begin
          if (w_release) begin
            r_state    <= ARB;
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_first    <= 1'b0;
          end else begin
            r_beat_cnt <= w_cnt_next;
            r_first    <= r_first & ~w_start;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign grant_o  = r_grant;
  assign m_HRDATA = HRDATA;
  assign HWDATA   = r_d_valid ? w_hwdata[r_d_own] : '0;

  // Non-owners see ready only while idle, so a pending NONSEQ stalls in place.
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_resp
    logic w_addr_owner;
    logic w_data_owner;
    assign w_addr_owner = (r_state == OWN) && (r_owner == IDX_W'(g));
    assign w_data_owner = r_d_valid && (r_d_own == IDX_W'(g));
    assign m_HREADY[g]  = (w_addr_owner || w_data_owner) ? HREADY : (w_htrans[g] == IDLE);
    assign m_HRESP[g]   = w_data_owner ? HRESP : 1'b0;
  end

endmodule
